// File: rtl/symbol_slicer.sv
// BPSK integrate-and-dump slicer with 10-bit comma alignment and word delivery.
// Ports: clk, reset, sample_in/sample_valid in; stop_in, sync_clear in; word_out/push_word/sync/invert/overrun out.
module symbol_slicer #(
  parameter int         SPS          = 16,
  parameter int         ACC_W        = 36,
  parameter logic [9:0] COMMA        = 10'b0011111010,
  parameter int         LOCK_COUNT   = 3,
  parameter int         MISALIGN_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  input  logic        stop_in,
  input  logic        sync_clear,
  output logic [9:0]  word_out,
  output logic        push_word,
  output logic        sync,
  output logic        invert,
  output logic        overrun
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N = 4'(MISALIGN_MAX);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    sample_cnt;
  logic [9:0]       shreg;
  logic             bit_strobe;
  logic             dump;

  assign sample_ext = {{(ACC_W-32){sample_in[31]}}, sample_in};
  assign sum        = acc + sample_ext;
  assign dump       = sample_valid && (sample_cnt == LAST);

  // Integrate-and-dump; decided bit is the inverted sign of the symbol sum,
  // so an exact zero sum decodes as 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      shreg      <= '0;
      bit_strobe <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      if (sample_valid) begin
        if (dump) begin
          acc        <= '0;
          sample_cnt <= '0;
          shreg      <= {shreg[8:0], ~sum[ACC_W-1]};
          bit_strobe <= 1'b1;
        end else begin
          acc        <= sum;
          sample_cnt <= sample_cnt + CW'(1);
        end
      end
    end
  end

  logic [1:0] state, state_n;
  logic       invert_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [3:0] comma_cnt, comma_n;
  logic [3:0] miss_cnt, miss_n;
  logic       load;
  logic       boundary;
  logic       is_comma, is_ncomma, any_comma;
  logic [9:0] pol_comma;
  logic [9:0] new_word;

  assign boundary  = (bit_cnt == 4'd9);
  assign is_comma  = (shreg == COMMA);
  assign is_ncomma = (shreg == ~COMMA);
  assign any_comma = is_comma || is_ncomma;
  assign pol_comma = invert ? ~COMMA : COMMA;
  assign new_word  = shreg ^ {10{invert}};
  assign sync      = (state == LOCKED);

  always_comb begin
    state_n   = state;
    invert_n  = invert;
    bit_cnt_n = bit_cnt;
    comma_n   = comma_cnt;
    miss_n    = miss_cnt;
    load      = 1'b0;
    if (bit_strobe) begin
      bit_cnt_n = boundary ? 4'd0 : bit_cnt + 4'd1;
      unique case (state)
        HUNT: begin
          if (any_comma) begin
            invert_n  = is_ncomma;
            bit_cnt_n = 4'd0;
            comma_n   = 4'd1;
            state_n   = VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (shreg == pol_comma) begin
              comma_n = comma_cnt + 4'd1;
              if (comma_n == LOCK_N) begin
                state_n = LOCKED;
                miss_n  = 4'd0;
              end
            end else begin
              state_n  = HUNT;
              invert_n = 1'b0;
              comma_n  = 4'd0;
            end
          end
        end
        LOCKED: begin
          load = boundary;
          if (boundary && (shreg == pol_comma)) begin
            miss_n = 4'd0;
          end else if (!boundary && any_comma) begin
            if (miss_cnt + 4'd1 == MISS_N) begin
              state_n  = HUNT;
              invert_n = 1'b0;
              miss_n   = 4'd0;
            end else begin
              miss_n = miss_cnt + 4'd1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
    if (sync_clear) begin
      state_n  = HUNT;
      invert_n = 1'b0;
      comma_n  = 4'd0;
      miss_n   = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      invert    <= 1'b0;
      bit_cnt   <= 4'd0;
      comma_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
    end else begin
      state     <= state_n;
      invert    <= invert_n;
      bit_cnt   <= bit_cnt_n;
      comma_cnt <= comma_n;
      miss_cnt  <= miss_n;
    end
  end

  logic [9:0] hold_word;
  logic       hold_valid;
  logic       release_w;

  assign release_w = hold_valid && !stop_in;

  // Single-entry hold: a release and a new load in the same cycle is a
  // clean handoff; a load onto an unreleased word overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
      word_out   <= '0;
      push_word  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      push_word <= 1'b0;
      overrun   <= 1'b0;
      if (release_w) begin
        push_word <= 1'b1;
        word_out  <= hold_word;
      end
      if (load) begin
        hold_word  <= new_word;
        hold_valid <= 1'b1;
        if (hold_valid && !release_w) overrun <= 1'b1;
      end else if (release_w) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_symbol_slicer.sv
// Directed bench for symbol_slicer.
// Drives BPSK symbols and checks lock, polarity, delivery, overrun, reset.
module tb_symbol_slicer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        stop_in;
  logic        sync_clear;
  logic [9:0]  word_out;
  logic        push_word;
  logic        sync;
  logic        invert;
  logic        overrun;

  symbol_slicer dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .stop_in(stop_in),
    .sync_clear(sync_clear),
    .word_out(word_out),
    .push_word(push_word),
    .sync(sync),
    .invert(invert),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] K  = 10'b0011111010;
  localparam logic [9:0] D  = 10'b1010101010;
  localparam logic [9:0] WA = 10'b1100110011;
  localparam logic [9:0] WB = 10'b0110011001;
  localparam logic [9:0] AB = 10'b0000011111;

  int errors = 0;
  int checks = 0;
  int push_cnt;
  int ovr_cnt;
  logic [9:0] last_word;
  logic sync_seen;
  logic neg;

  always @(negedge clk) begin
    if (push_word) begin
      push_cnt++;
      last_word = word_out;
    end
    if (overrun) ovr_cnt++;
    if (sync) sync_seen = 1'b1;
  end

  task automatic drive(input logic signed [31:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    for (int i = 0; i < 16; i++)
      drive((b ^ neg) ? 32'sd1000 : -32'sd1000);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    sample_valid = 1'b0;
    stop_in = 1'b0;
    sync_clear = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_cnt = 0;
    ovr_cnt = 0;
    sync_seen = 1'b0;
    last_word = '0;
  endtask

  task automatic lock3;
    repeat (3) send_word(K);
    idle(2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    stop_in = 1'b0;
    sync_clear = 1'b0;
    neg = 1'b0;
    push_cnt = 0;
    ovr_cnt = 0;
    sync_seen = 1'b0;
    #1;
    checks++;
    if (sync !== 1'b0) begin
      errors++; $display("FAIL rst_sync: got %b want 0", sync);
    end
    checks++;
    if (invert !== 1'b0) begin
      errors++; $display("FAIL rst_invert: got %b want 0", invert);
    end
    checks++;
    if (push_word !== 1'b0) begin
      errors++; $display("FAIL rst_push: got %b want 0", push_word);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL rst_overrun: got %b want 0", overrun);
    end
    checks++;
    if (word_out !== 10'd0) begin
      errors++; $display("FAIL rst_word: got %b want 0", word_out);
    end
    do_reset();
  endtask

  task automatic test_lock;
    do_reset();
    neg = 1'b0;
    send_word(K);
    send_word(K);
    send_word(K);
    checks++;
    if (sync !== 1'b0) begin
      errors++; $display("FAIL lock_early: got %b want 0", sync);
    end
    @(posedge clk); #1;
    checks++;
    if (sync !== 1'b1) begin
      errors++; $display("FAIL lock_sync: got %b want 1", sync);
    end
    send_word(D);
    checks++;
    if (push_word !== 1'b0) begin
      errors++; $display("FAIL lat_e0: got %b want 0", push_word);
    end
    @(posedge clk); #1;
    checks++;
    if (push_word !== 1'b0) begin
      errors++; $display("FAIL lat_e1: got %b want 0", push_word);
    end
    @(posedge clk); #1;
    checks++;
    if (push_word !== 1'b1 || word_out !== D) begin
      errors++;
      $display("FAIL lat_e2: got push=%b word=%b want 1 %b", push_word, word_out, D);
    end
    idle(5);
    checks++;
    if (push_cnt != 1) begin
      errors++; $display("FAIL lock_pushes: got %0d want 1", push_cnt);
    end
    checks++;
    if (last_word !== D) begin
      errors++; $display("FAIL lock_word: got %b want %b", last_word, D);
    end
    checks++;
    if (invert !== 1'b0) begin
      errors++; $display("FAIL lock_invert: got %b want 0", invert);
    end
  endtask

  task automatic test_invert;
    do_reset();
    neg = 1'b1;
    lock3();
    send_word(D);
    idle(5);
    neg = 1'b0;
    checks++;
    if (invert !== 1'b1) begin
      errors++; $display("FAIL inv_flag: got %b want 1", invert);
    end
    checks++;
    if (sync !== 1'b1) begin
      errors++; $display("FAIL inv_sync: got %b want 1", sync);
    end
    checks++;
    if (push_cnt != 1 || last_word !== D) begin
      errors++;
      $display("FAIL inv_word: got %0d pushes word=%b want 1 %b", push_cnt, last_word, D);
    end
  endtask

  task automatic test_abort;
    do_reset();
    neg = 1'b0;
    send_word(K);
    send_word(K);
    send_word(AB);
    idle(5);
    checks++;
    if (sync_seen !== 1'b0) begin
      errors++; $display("FAIL abort_sync: got %b want 0", sync_seen);
    end
    checks++;
    if (push_cnt != 0) begin
      errors++; $display("FAIL abort_push: got %0d want 0", push_cnt);
    end
  endtask

  task automatic test_misalign;
    do_reset();
    neg = 1'b0;
    lock3();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_word(K);
    @(posedge clk); #1;
    checks++;
    if (sync !== 1'b1) begin
      errors++; $display("FAIL mis_first: got %b want 1", sync);
    end
    send_word(K);
    @(posedge clk); #1;
    checks++;
    if (sync !== 1'b0) begin
      errors++; $display("FAIL mis_drop: got %b want 0", sync);
    end
    send_word(K);
    send_word(K);
    @(posedge clk); #1;
    checks++;
    if (sync !== 1'b0) begin
      errors++; $display("FAIL relock_early: got %b want 0", sync);
    end
    send_word(K);
    @(posedge clk); #1;
    checks++;
    if (sync !== 1'b1) begin
      errors++; $display("FAIL relock: got %b want 1", sync);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    neg = 1'b0;
    lock3();
    stop_in = 1'b1;
    send_word(WA);
    send_word(WB);
    idle(4);
    checks++;
    if (ovr_cnt != 1) begin
      errors++; $display("FAIL stop_overrun: got %0d want 1", ovr_cnt);
    end
    checks++;
    if (push_cnt != 0) begin
      errors++; $display("FAIL stop_held: got %0d want 0", push_cnt);
    end
    stop_in = 1'b0;
    idle(4);
    checks++;
    if (push_cnt != 1 || last_word !== WB) begin
      errors++;
      $display("FAIL stop_release: got %0d pushes word=%b want 1 %b", push_cnt, last_word, WB);
    end
  endtask

  task automatic test_zero_sum;
    do_reset();
    neg = 1'b0;
    lock3();
    for (int i = 0; i < 8; i++) drive(32'sd500);
    for (int i = 0; i < 8; i++) drive(-32'sd500);
    for (int i = 8; i >= 0; i--) send_bit(D[i]);
    idle(5);
    checks++;
    if (push_cnt != 1 || last_word !== D) begin
      errors++;
      $display("FAIL zero_sum: got %0d pushes word=%b want 1 %b", push_cnt, last_word, D);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    neg = 1'b1;
    lock3();
    send_word(D);
    idle(4);
    for (int i = 0; i < 8; i++) drive(32'sd100000);
    sample_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (sync !== 1'b0 || invert !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_flags: got sync=%b inv=%b want 0 0", sync, invert);
    end
    checks++;
    if (word_out !== 10'd0 || push_word !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out: got word=%b push=%b ovr=%b want 0", word_out, push_word, overrun);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    push_cnt = 0;
    sync_seen = 1'b0;
    neg = 1'b0;
    send_word(K);
    send_word(K);
    idle(2);
    checks++;
    if (sync_seen !== 1'b0) begin
      errors++; $display("FAIL mid_rst_nosync: got %b want 0", sync_seen);
    end
    send_word(K);
    idle(2);
    send_word(D);
    idle(5);
    checks++;
    if (push_cnt != 1 || last_word !== D) begin
      errors++;
      $display("FAIL mid_rst_relock: got %0d pushes word=%b want 1 %b", push_cnt, last_word, D);
    end
  endtask

  task automatic test_sync_clear;
    do_reset();
    neg = 1'b1;
    lock3();
    neg = 1'b0;
    checks++;
    if (sync !== 1'b1 || invert !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre: got sync=%b inv=%b want 1 1", sync, invert);
    end
    sync_clear = 1'b1;
    @(posedge clk); #1;
    sync_clear = 1'b0;
    checks++;
    if (sync !== 1'b0 || invert !== 1'b0) begin
      errors++;
      $display("FAIL clr_post: got sync=%b inv=%b want 0 0", sync, invert);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_invert();
    test_abort();
    test_misalign();
    test_back_to_back();
    test_zero_sum();
    test_reset_mid();
    test_sync_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
